// File: rtl/mkmif_sram_model_if.sv
// SPI pin bundle between an MKM SPI master and the 23K640-style SRAM model.
interface mkmif_sram_model_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_di;
  logic spi_do;
  logic spi_do_en;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_di,
    input  spi_do,
    input  spi_do_en
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_di,
    output spi_do,
    output spi_do_en
  );
endinterface

// File: rtl/mkmif_sram_model.sv
// Synthesizable 23K640 serial SRAM emulator: SPI mode 0 slave, oversampled in the clk domain.
// Supports READ 0x03, WRITE 0x02, RDSR 0x05 and WRSR 0x01 over a 2**ADDR_BITS byte array.
// Page mode assumes ADDR_BITS >= 5 (32-byte pages).
module mkmif_sram_model #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mkmif_sram_model_if.slave    spi,
  output logic                 busy,
  output logic [7:0]           status,
  output logic                 cmd_error
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PageMask = ADDR_BITS'(31);

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddrHi, StAddrLo, StRdData, StWrData, StRdStatus, StWrStatus, StIgnore
  } state_e;

  state_e               state_q;
  logic [2:0]           sclk_sync;
  logic [2:0]           cs_sync;
  logic [1:0]           di_sync;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           rx_q;
  logic [7:0]           tx_q;
  logic [7:0]           addr_hi_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rd_cmd_q;
  logic                 load_q;
  logic                 wr_en_q;
  logic [7:0]           wr_byte_q;
  logic                 wr_seen_q;
  logic [7:0]           mem [Depth];

  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 cs_fall;
  logic                 cs_rise;
  logic [7:0]           rx_next;
  logic                 byte_done;
  logic                 byte_mode;
  logic [ADDR_BITS-1:0] next_addr;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b111;
      di_sync   <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi.spi_sclk};
      cs_sync   <= {cs_sync[1:0], spi.spi_cs_n};
      di_sync   <= {di_sync[0], spi.spi_di};
    end
  end

  // Edge decode, incoming byte assembly and address advance selection.
  always_comb begin
    sclk_rise = sclk_sync[1] & ~sclk_sync[2] & ~cs_sync[1];
    sclk_fall = ~sclk_sync[1] & sclk_sync[2] & ~cs_sync[1];
    cs_fall   = ~cs_sync[1] & cs_sync[2];
    cs_rise   = cs_sync[1] & ~cs_sync[2];
    rx_next   = {rx_q[6:0], di_sync[1]};
    byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    byte_mode = (status[7:6] == 2'b00) || (status[7:6] == 2'b11);
    unique case (status[7:6])
      2'b01:   next_addr = addr_q + ADDR_BITS'(1);
      2'b10:   next_addr = (addr_q & ~PageMask) | ((addr_q + ADDR_BITS'(1)) & PageMask);
      default: next_addr = addr_q;
    endcase
  end

  // Memory array, deliberately not reset; written the cycle after a byte completes.
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[addr_q] <= wr_byte_q;
  end

  // Transaction FSM with registered pin and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      addr_hi_q     <= 8'h00;
      addr_q        <= '0;
      rd_cmd_q      <= 1'b0;
      load_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_byte_q     <= 8'h00;
      wr_seen_q     <= 1'b0;
      busy          <= 1'b0;
      status        <= 8'h00;
      cmd_error     <= 1'b0;
      spi.spi_do    <= 1'b0;
      spi.spi_do_en <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      load_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      if (load_q) tx_q <= mem[addr_q];
      // Advance only after the write has used the current address.
      if (wr_en_q) addr_q <= next_addr;
      if (sclk_rise && state_q != StIdle) begin
        rx_q      <= rx_next;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (sclk_fall && (state_q == StRdData || state_q == StRdStatus)) begin
        spi.spi_do <= tx_q[7];
        tx_q       <= {tx_q[6:0], 1'b0};
      end
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StCmd;
            bit_cnt_q <= 3'd0;
            busy      <= 1'b1;
          end
        end
        StCmd: begin
          if (byte_done) begin
            case (rx_next)
              8'h03: begin
                rd_cmd_q <= 1'b1;
                state_q  <= StAddrHi;
              end
              8'h02: begin
                rd_cmd_q <= 1'b0;
                state_q  <= StAddrHi;
              end
              8'h05: begin
                tx_q          <= status;
                spi.spi_do_en <= 1'b1;
                state_q       <= StRdStatus;
              end
              8'h01:   state_q <= StWrStatus;
              default: begin
                cmd_error <= 1'b1;
                state_q   <= StIgnore;
              end
            endcase
          end
        end
        StAddrHi: begin
          if (byte_done) begin
            addr_hi_q <= rx_next;
            state_q   <= StAddrLo;
          end
        end
        StAddrLo: begin
          if (byte_done) begin
            // Upper address bits are dropped, so the array aliases.
            addr_q <= ADDR_BITS'({addr_hi_q, rx_next});
            if (rd_cmd_q) begin
              load_q        <= 1'b1;
              spi.spi_do_en <= 1'b1;
              state_q       <= StRdData;
            end else begin
              wr_seen_q <= 1'b0;
              state_q   <= StWrData;
            end
          end
        end
        StRdData: begin
          if (byte_done) begin
            addr_q <= next_addr;
            load_q <= 1'b1;
          end
        end
        StWrData: begin
          if (byte_done) begin
            // Byte mode accepts only the first data byte of a transaction.
            if (!(byte_mode && wr_seen_q)) begin
              wr_en_q   <= 1'b1;
              wr_byte_q <= rx_next;
            end
            wr_seen_q <= 1'b1;
          end
        end
        StRdStatus: begin
          if (byte_done) tx_q <= status;
        end
        StWrStatus: begin
          if (byte_done) begin
            status  <= {rx_next[7:6], 5'b00000, rx_next[0]};
            state_q <= StIgnore;
          end
        end
        default: ;
      endcase
      if (cs_rise) begin
        state_q       <= StIdle;
        busy          <= 1'b0;
        bit_cnt_q     <= 3'd0;
        load_q        <= 1'b0;
        spi.spi_do    <= 1'b0;
        spi.spi_do_en <= 1'b0;
      end
    end
  end

endmodule
